// File: rtl/gpr_wb_arbiter_if.sv
// Writeback bus between the pipeline / mul-div unit and the register-file write driver.
interface gpr_wb_arbiter_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          pipe_wr;
    logic [AW-1:0] pipe_rw;
    logic [DW-1:0] pipe_data;
    logic          pipe_ovf;
    logic          md_valid;
    logic          md_ready;
    logic [AW-1:0] md_rw;
    logic [DW-1:0] md_data;
    logic          issue_md;
    logic [AW-1:0] issue_rw;
    logic [31:0]   busy;
    logic [AW-1:0] rW;
    logic [DW-1:0] busW;
    logic          regWr;
    logic [1:0]    regDst;
    logic [CW-1:0] q_count;

    // Producer side: pipeline, mul/div unit and decode.
    modport master (
        output pipe_wr, pipe_rw, pipe_data, pipe_ovf,
        output md_valid, md_rw, md_data, issue_md, issue_rw,
        input  md_ready, busy, rW, busW, regWr, regDst, q_count
    );

    // Arbiter side.
    modport slave (
        input  pipe_wr, pipe_rw, pipe_data, pipe_ovf,
        input  md_valid, md_rw, md_data, issue_md, issue_rw,
        output md_ready, busy, rW, busW, regWr, regDst, q_count
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Merges pipeline and buffered mul/div results onto the single register-file write port,
// and tracks outstanding mul/div destinations in a per-register scoreboard.
module gpr_wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input logic              clk,
    input logic              rst,
    gpr_wb_arbiter_if.slave  wb
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] rw;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   busy_q, busy_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] busw_q, busw_d;
    logic          regwr_q, regwr_d;
    logic [1:0]    regdst_q, regdst_d;

    entry_t head;
    logic   push;
    logic   pop;

    assign head        = mem_q[rd_ptr_q];
    // Based on registered count only: a full FIFO refuses a push even while popping.
    assign wb.md_ready = (count_q < CW'(DEPTH)) && !rst;
    assign push        = wb.md_valid && wb.md_ready;
    // Pipe writes always win the port, so the FIFO only drains on pipe-idle cycles.
    assign pop         = !wb.pipe_wr && (count_q != '0);

    // Next-state for FIFO pointers, occupancy, scoreboard and the write-port registers.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Clear first so a same-cycle issue to the same register wins.
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.rw] = 1'b0;
        end
        if (wb.issue_md) begin
            busy_d[wb.issue_rw] = 1'b1;
        end
        busy_d[0] = 1'b0;

        rw_d     = rw_q;
        busw_d   = busw_q;
        regwr_d  = 1'b0;
        regdst_d = 2'b00;
        if (wb.pipe_wr && !wb.pipe_ovf) begin
            rw_d    = wb.pipe_rw;
            busw_d  = wb.pipe_data;
            regwr_d = (wb.pipe_rw != '0);
        end else if (wb.pipe_wr) begin
            // Overflow is reported by writing r30 with the flag destination code.
            rw_d     = AW'(30);
            busw_d   = '0;
            regwr_d  = 1'b1;
            regdst_d = 2'b11;
        end else if (pop) begin
            rw_d    = head.rw;
            busw_d  = head.data;
            regwr_d = (head.rw != '0);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            rw_q     <= '0;
            busw_q   <= '0;
            regwr_q  <= 1'b0;
            regdst_q <= 2'b00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
            regwr_q  <= regwr_d;
            regdst_q <= regdst_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rw: wb.md_rw, data: wb.md_data};
        end
    end

    assign wb.busy    = busy_q;
    assign wb.rW      = rw_q;
    assign wb.busW    = busw_q;
    assign wb.regWr   = regwr_q;
    assign wb.regDst  = regdst_q;
    assign wb.q_count = count_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with hand-computed expectations.
module tb_gpr_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter_if #(.DEPTH(4), .DW(32), .AW(5)) wb ();

    gpr_wb_arbiter #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb.pipe_wr   = 1'b0;
        wb.pipe_rw   = '0;
        wb.pipe_data = '0;
        wb.pipe_ovf  = 1'b0;
        wb.md_valid  = 1'b0;
        wb.md_rw     = '0;
        wb.md_data   = '0;
        wb.issue_md  = 1'b0;
        wb.issue_rw  = '0;
    endtask

    logic [4:0] exp_rw [5];

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk("ready_in_rst", wb.md_ready, 0);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_regwr", wb.regWr, 0);
        chk("idle_regdst", wb.regDst, 0);
        chk("idle_busy", wb.busy, 0);
        chk("idle_count", wb.q_count, 0);
        chk("idle_ready", wb.md_ready, 1);

        // Plain pipe write.
        wb.pipe_wr = 1'b1; wb.pipe_rw = 5'd8; wb.pipe_data = 32'h1234_5678;
        step();
        idle_inputs();
        chk("pipe_rw", wb.rW, 8);
        chk("pipe_busw", wb.busW, 32'h1234_5678);
        chk("pipe_regwr", wb.regWr, 1);
        chk("pipe_regdst", wb.regDst, 0);
        step();
        chk("pipe_regwr_off", wb.regWr, 0);
        chk("pipe_rw_hold", wb.rW, 8);
        chk("pipe_busw_hold", wb.busW, 32'h1234_5678);

        // Overflow write.
        wb.pipe_wr = 1'b1; wb.pipe_ovf = 1'b1; wb.pipe_rw = 5'd9; wb.pipe_data = 32'hCAFE_0001;
        step();
        idle_inputs();
        chk("ovf_rw", wb.rW, 30);
        chk("ovf_busw", wb.busW, 0);
        chk("ovf_regdst", wb.regDst, 3);
        chk("ovf_regwr", wb.regWr, 1);

        // Pipe write to r0 is suppressed.
        wb.pipe_wr = 1'b1; wb.pipe_rw = 5'd0; wb.pipe_data = 32'h0000_00AA;
        step();
        idle_inputs();
        chk("pipe_r0_regwr", wb.regWr, 0);

        // Issue, then result, then writeback with scoreboard clear.
        wb.issue_md = 1'b1; wb.issue_rw = 5'd5;
        step();
        idle_inputs();
        chk("md_busy_set", wb.busy, 32'h0000_0020);
        step();
        step();
        chk("md_busy_hold", wb.busy, 32'h0000_0020);
        wb.md_valid = 1'b1; wb.md_rw = 5'd5; wb.md_data = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        chk("md_push_count", wb.q_count, 1);
        chk("md_push_nowr", wb.regWr, 0);
        chk("md_push_busy", wb.busy, 32'h0000_0020);
        step();
        chk("md_pop_regwr", wb.regWr, 1);
        chk("md_pop_rw", wb.rW, 5);
        chk("md_pop_busw", wb.busW, 32'hDEAD_BEEF);
        chk("md_pop_busy", wb.busy, 0);
        chk("md_pop_count", wb.q_count, 0);

        // Fill FIFO under continuous pipe traffic.
        wb.pipe_wr = 1'b1; wb.pipe_rw = 5'd1; wb.pipe_data = 32'h0000_0055;
        for (int i = 0; i < 4; i++) begin
            exp_rw[i]   = 5'(10 + i);
            wb.md_valid = 1'b1;
            wb.md_rw    = 5'(10 + i);
            wb.md_data  = 32'hA0 + 32'(i);
            chk("fill_ready", wb.md_ready, 1);
            step();
            chk("fill_count", wb.q_count, 64'(i + 1));
            chk("fill_pipe_rw", wb.rW, 1);
        end
        exp_rw[4]  = 5'd14;
        wb.md_rw   = 5'd14;
        wb.md_data = 32'hA4;
        chk("full_ready", wb.md_ready, 0);
        chk("full_count", wb.q_count, 4);
        step();
        chk("full_hold_count", wb.q_count, 4);
        chk("full_hold_ready", wb.md_ready, 0);

        // Drain: the held 5th result enters once a slot frees.
        wb.pipe_wr = 1'b0;
        step();
        chk("drain0_rw", wb.rW, exp_rw[0]);
        chk("drain0_busw", wb.busW, 32'hA0);
        chk("drain0_count", wb.q_count, 3);
        chk("drain0_ready", wb.md_ready, 1);
        step();
        wb.md_valid = 1'b0;
        chk("drain1_rw", wb.rW, exp_rw[1]);
        chk("drain1_count", wb.q_count, 3);
        for (int i = 2; i < 5; i++) begin
            step();
            chk("drain_rw", wb.rW, exp_rw[i]);
            chk("drain_busw", wb.busW, 32'hA0 + 32'(i));
            chk("drain_regwr", wb.regWr, 1);
            chk("drain_count", wb.q_count, 64'(4 - i));
        end
        step();
        chk("drain_done_regwr", wb.regWr, 0);
        chk("drain_busy", wb.busy, 0);

        // Issue to r7 in the cycle its older result pops: set wins.
        wb.issue_md = 1'b1; wb.issue_rw = 5'd7;
        step();
        idle_inputs();
        chk("r7_busy_set", wb.busy, 32'h0000_0080);
        wb.md_valid = 1'b1; wb.md_rw = 5'd7; wb.md_data = 32'h77;
        step();
        idle_inputs();
        wb.issue_md = 1'b1; wb.issue_rw = 5'd7;
        step();
        idle_inputs();
        chk("r7_pop_rw", wb.rW, 7);
        chk("r7_pop_regwr", wb.regWr, 1);
        chk("r7_busy_kept", wb.busy, 32'h0000_0080);

        // r0 result is popped but not written.
        wb.md_valid = 1'b1; wb.md_rw = 5'd0; wb.md_data = 32'h99;
        step();
        idle_inputs();
        chk("r0_push_count", wb.q_count, 1);
        step();
        chk("r0_pop_regwr", wb.regWr, 0);
        chk("r0_pop_rw", wb.rW, 0);
        chk("r0_pop_busw", wb.busW, 32'h99);
        chk("r0_pop_count", wb.q_count, 0);
        chk("r0_busy", wb.busy, 32'h0000_0080);

        // Queue three entries behind pipe traffic, then reset.
        wb.pipe_wr = 1'b1; wb.pipe_rw = 5'd3; wb.pipe_data = 32'h33;
        for (int i = 0; i < 3; i++) begin
            wb.md_valid = 1'b1;
            wb.md_rw    = 5'(4 + 2 * i);
            wb.md_data  = 32'hB0 + 32'(i);
            wb.issue_md = 1'b1;
            wb.issue_rw = 5'(20 + i);
            step();
        end
        chk("pre_rst_count", wb.q_count, 3);
        chk("pre_rst_busy", wb.busy, 32'h0070_0080);
        idle_inputs();
        wb.md_valid = 1'b1; wb.md_rw = 5'd2; wb.md_data = 32'hEE;
        rst = 1'b1;
        #1;
        chk("rst_ready", wb.md_ready, 0);
        step();
        chk("rst_count", wb.q_count, 0);
        chk("rst_busy", wb.busy, 0);
        chk("rst_regwr", wb.regWr, 0);
        chk("rst_rw", wb.rW, 0);
        chk("rst_busw", wb.busW, 0);
        chk("rst_regdst", wb.regDst, 0);
        idle_inputs();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_regwr", wb.regWr, 0);
            chk("post_rst_count", wb.q_count, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
